// File: rtl/oh_cdc_arbiter_if.sv
// Requester/channel bundle for oh_cdc_arbiter.
// slave = arbiter side, master = requesters plus destination ack.
interface oh_cdc_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            tx_req;
  logic [DW-1:0]   tx_data;
  logic            tx_ack;
  logic            busy;
  logic [IW-1:0]   grant_id;

  modport master (
    output in_valid, in_data, tx_ack,
    input  in_ready, tx_req, tx_data,
    input  busy, grant_id
  );

  modport slave (
    input  in_valid, in_data, tx_ack,
    output in_ready, tx_req, tx_data,
    output busy, grant_id
  );
endinterface

// File: rtl/oh_cdc_arbiter.sv
// Round-robin arbiter feeding one 4-phase req/ack clock-crossing channel.
// tx_ack is resynchronized through a PS-flop pipe before the FSM uses it.
module oh_cdc_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int PS = 2
) (
  input logic             clk,
  input logic             nreset,
  oh_cdc_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic            tx_req_q, tx_req_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [PS-1:0]   sync_q, sync_d;
  logic            ack_sync;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [N-1:0]    ready;

  assign sync_d   = {sync_q[PS-2:0], bus.tx_ack};
  assign ack_sync = sync_q[PS-1];

  // first valid requester after the last grant, wrapping
  always_comb begin
    logic [IW-1:0] cand;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(grant_q) + k) % N);
      if (!win_vld && bus.in_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (nreset && state_q == IDLE && win_vld)
      ready = N'(1) << win_idx;
  end

  always_comb begin
    state_d   = state_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = REQ;
          tx_req_d  = 1'b1;
          tx_data_d = bus.in_data[win_idx*DW +: DW];
          grant_d   = win_idx;
        end
      end
      REQ: begin
        if (ack_sync) begin
          state_d  = RELEASE;
          tx_req_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!ack_sync)
          state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        tx_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      grant_q   <= IW'(N - 1);
      busy_q    <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.tx_req   = tx_req_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_oh_cdc_arbiter.sv
// Bench for oh_cdc_arbiter: transaction-level model plus directed
// scenarios and a randomized soak.
module tb_oh_cdc_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PS = 2;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    vld = '0;
  logic [N*DW-1:0] dat = '0;
  logic            ack_r = 1'b0;

  oh_cdc_arbiter_if #(.N(N), .DW(DW)) bus();

  assign bus.in_valid = vld;
  assign bus.in_data  = dat;
  assign bus.tx_ack   = ack_r;

  oh_cdc_arbiter #(.N(N), .DW(DW), .PS(PS)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int g);
    for (int k = 1; k <= N; k++)
      if (v[(g + k) % N]) return (g + k) % N;
    return -1;
  endfunction

  // transfer-level model: phase 0 idle, 1 requesting, 2 releasing
  int            m_ph = 0;
  logic [DW-1:0] m_data = '0;
  int            m_gid = N - 1;
  logic [PS-1:0] m_ackh = '0;
  bit            chk_en = 1'b0;
  int            acc_q[$];

  always @(posedge clk) begin
    int  w;
    logic seen;
    if (!nreset) begin
      m_ph   = 0;
      m_data = '0;
      m_gid  = N - 1;
      m_ackh = '0;
      chk_en = 1'b1;
    end else begin
      seen = m_ackh[PS-1];
      if (m_ph == 0) begin
        w = winner(vld, m_gid);
        if (w >= 0) begin
          m_data = dat[w*DW +: DW];
          m_gid  = w;
          m_ph   = 1;
        end
      end else if (m_ph == 1) begin
        if (seen) m_ph = 2;
      end else begin
        if (!seen) m_ph = 0;
      end
      m_ackh = {m_ackh[PS-2:0], ack_r};
    end
  end

  always @(negedge clk) begin
    int w;
    logic [N-1:0] exp_rdy;
    if (chk_en) begin
      w = winner(vld, m_gid);
      exp_rdy = '0;
      if (nreset && m_ph == 0 && w >= 0) exp_rdy[w] = 1'b1;
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      chk("tx_req", 64'(bus.tx_req), 64'(m_ph == 1));
      chk("tx_data", 64'(bus.tx_data), 64'(m_data));
      chk("busy", 64'(bus.busy), 64'(m_ph != 0));
      chk("grant_id", 64'(bus.grant_id), 64'(m_gid));
      if (nreset)
        for (int i = 0; i < N; i++)
          if (vld[i] && bus.in_ready[i]) acc_q.push_back(i);
    end
  end

  // ack source: 0 manual, 1 follow tx_req, 2 follow with random noise
  int   ack_mode = 0;
  logic ack_man = 1'b0;
  int   ack_dly = 1;
  logic [7:0] rq_h = '0;

  always @(posedge clk) begin
    #3;
    rq_h = {rq_h[6:0], bus.tx_req};
    if (ack_mode == 0) ack_r = ack_man;
    else if (ack_mode == 1) ack_r = rq_h[ack_dly];
    else if ($urandom_range(0, 3) == 0) ack_r = 1'($urandom_range(0, 1));
    else ack_r = rq_h[ack_dly];
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    #1;
    while (bus.busy && n < 100) begin
      tick();
      #1;
      n++;
    end
    if (bus.busy) chk({name, "_timeout"}, 64'(1), 64'(0));
  endtask

  task automatic count_busy_fall(input string name, input int exp_n);
    int n = 0;
    do begin
      tick();
      #1;
      n++;
    end while (bus.busy && n < 30);
    chk(name, 64'(n), 64'(exp_n));
  endtask

  task automatic wait_acc(input string name, input int cnt);
    int n = 0;
    while (acc_q.size() < cnt && n < 400) begin
      tick();
      n++;
    end
    if (acc_q.size() < cnt) chk({name, "_timeout"}, 64'(acc_q.size()),
                                64'(cnt));
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    repeat (2) tick();
    nreset = 1'b1;
  endtask

  initial begin
    int n;
    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
    int exp_gap[4] = '{0, 3, 0, 3};
    for (int i = 0; i < N; i++) dat[i*DW +: DW] = 32'hA000_0000 + i;

    // reset with everything asserted
    vld = 4'b1111;
    ack_man = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_tx_req", 64'(bus.tx_req), 64'(0));
    chk("rst_tx_data", 64'(bus.tx_data), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_grant_id", 64'(bus.grant_id), 64'(3));
    ack_man = 1'b0;
    nreset = 1'b1;
    #1;
    chk("first_winner", 64'(bus.in_ready), 64'(4'b0001));
    tick();
    vld = '0;
    ack_mode = 1;
    ack_dly = 1;
    wait_idle("t1");

    // single transfer with manual ack
    ack_mode = 0;
    ack_man = 1'b0;
    tick();
    vld = 4'b0100;
    dat[2*DW +: DW] = 32'hCAFE_0002;
    #1;
    chk("single_ready", 64'(bus.in_ready), 64'(4'b0100));
    tick();
    vld = '0;
    #1;
    chk("single_req", 64'(bus.tx_req), 64'(1));
    chk("single_data", 64'(bus.tx_data), 64'(32'hCAFE_0002));
    repeat (2) tick();
    ack_man = 1'b1;
    n = 0;
    while (bus.tx_req && n < 20) begin
      tick();
      n++;
    end
    chk("single_req_fall", 64'(bus.tx_req), 64'(0));
    repeat (2) tick();
    ack_man = 1'b0;
    count_busy_fall("single_busy_fall", PS + 1);
    chk("single_data_hold", 64'(bus.tx_data), 64'(32'hCAFE_0002));

    // round robin with all requesters valid
    do_reset();
    ack_mode = 1;
    acc_q.delete();
    vld = 4'b1111;
    wait_acc("rr", 6);
    vld = '0;
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), 64'(acc_q[i]), 64'(exp_rr[i]));
    wait_idle("t3");

    // gap pattern, then late-arriving requester 2
    do_reset();
    acc_q.delete();
    vld = 4'b1001;
    wait_acc("gap", 5);
    chk("gap_grant0", 64'(bus.grant_id), 64'(0));
    vld = 4'b1101;
    wait_acc("gap2", 6);
    vld = '0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("gap_order%0d", i), 64'(acc_q[i]), 64'(exp_gap[i]));
    chk("gap_late2", 64'(acc_q[5]), 64'(2));
    wait_idle("t4");

    // reset in the middle of a handshake
    ack_mode = 0;
    ack_man = 1'b0;
    tick();
    vld = 4'b0001;
    tick();
    vld = '0;
    #1;
    chk("mid_req_up", 64'(bus.tx_req), 64'(1));
    nreset = 1'b0;
    tick();
    #1;
    chk("mid_req_drop", 64'(bus.tx_req), 64'(0));
    chk("mid_busy", 64'(bus.busy), 64'(0));
    nreset = 1'b1;
    vld = 4'b0010;
    dat[1*DW +: DW] = 32'h1234_5678;
    #1;
    chk("mid_next_ready", 64'(bus.in_ready), 64'(4'b0010));
    tick();
    vld = '0;
    #1;
    chk("mid_next_data", 64'(bus.tx_data), 64'(32'h1234_5678));
    ack_mode = 1;
    wait_idle("t5");

    // ack stuck high before acceptance
    ack_mode = 0;
    ack_man = 1'b1;
    repeat (4) tick();
    vld = 4'b0100;
    tick();
    vld = '0;
    #1;
    chk("stuck_req", 64'(bus.tx_req), 64'(1));
    tick();
    #1;
    chk("stuck_req_1cyc", 64'(bus.tx_req), 64'(0));
    vld = 4'b1111;
    repeat (3) tick();
    #1;
    chk("stuck_busy", 64'(bus.busy), 64'(1));
    chk("stuck_ready", 64'(bus.in_ready), 64'(0));
    vld = '0;
    tick();
    ack_man = 1'b0;
    count_busy_fall("stuck_release", PS + 1);

    // randomized soak
    ack_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      tick();
      vld = N'($urandom);
      for (int i = 0; i < N; i++) dat[i*DW +: DW] = $urandom;
      nreset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 49) == 0) ack_dly = $urandom_range(0, 3);
    end
    nreset = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oh_cdc_arbiter.md
Name: oh_cdc_arbiter

Overview:
- Round-robin arbiter and 4-phase req/ack handshake controller. It shares one clock-crossing channel between N requesters in the source domain.
- A granted requester's word is latched and presented on tx_data with tx_req. The asynchronous tx_ack returning from the destination domain is resynchronized internally through a PS-stage flop pipe.
- Sits in front of async links and config buses that cross into another clock domain.

Parameters:
- N, 4, number of requesters (>=2)
- DW, 32, data width per requester
- PS, 2, number of synchronizer stages on tx_ack (>=2)

Ports:
- clk, input, 1, clock
- nreset, input, 1, synchronous active-low reset
- in_valid, input, N, per-requester valid
- in_data, input, N*DW, requester i occupies bits [i*DW+DW-1:i*DW]
- in_ready, output, N, one-hot or zero; accept strobe for requester i
- tx_req, output, 1, registered 4-phase request to the destination domain
- tx_data, output, DW, registered data, stable while tx_req high or ack_sync high
- tx_ack, input, 1, asynchronous acknowledge from the destination domain
- busy, output, 1, high in any state other than IDLE
- grant_id, output, clog2(N), index of last accepted requester (registered)

Behaviour:
Reset
- Synchronous, active-low, sampled at posedge clk.
- While nreset=0: state=IDLE, tx_req=0, tx_data=0, ack sync pipe=0, busy=0, grant_id=N-1 (so requester 0 wins first).
- Reset mid-handshake aborts the transfer: tx_req drops on the reset edge, and the word is lost.

Ack synchronizer
- ack_sync is the output of a PS-flop chain on tx_ack.
- A tx_ack edge is seen by the FSM exactly PS cycles after the first capturing clk edge.

Arbitration
- Evaluated only in IDLE.
- Winner is the first i with in_valid[i]=1, searching (grant_id+1) mod N upward with wraparound.
- in_ready[winner]=1 combinationally in IDLE; all other in_ready bits are 0.
- in_ready=0 in every other state.
- Transfer occurs on the cycle where in_valid[i]&in_ready[i]=1. On that edge: tx_data<=in_data[i], grant_id<=i, tx_req<=1, state<=REQ.
- Requesters may drop in_valid at any time before acceptance without effect.

FSM
- IDLE: accept as above. With no valid requester, stay in IDLE.
- REQ: tx_req=1. When ack_sync=1: tx_req<=0, state<=RELEASE.
- RELEASE: tx_req=0, tx_data held. When ack_sync=0: state<=IDLE.
- Next arbitration happens in the IDLE cycle itself, so back-to-back transfers have exactly one IDLE cycle between them.

Ack edge cases
- tx_ack already high on entry to IDLE or REQ (protocol violation): REQ completes immediately on the first cycle ack_sync=1. No lockup.
- A glitch on tx_ack shorter than one clk period may or may not be captured. Either outcome must leave the FSM in a legal state.

Timing
- Latency from accept to tx_req high: 1 cycle.
- Minimum full-handshake period: accept + 1 + PS (ack rise) + 1 + PS (ack fall) + 1 IDLE cycle.

Fairness
- With all N requesters continuously valid, the grant order is 0,1,...,N-1,0,...
- No requester waits more than N-1 other transfers.

Invariants
- in_ready popcount <= 1.
- tx_data changes only on accept edges or reset.
- tx_req never rises while ack_sync=1 in RELEASE.

Test Plan:
1. Reset: hold nreset=0 for 3 cycles with in_valid=4'b1111 and tx_ack=1 -> tx_req=0, tx_data=0, in_ready=0, busy=0, grant_id=3. First accept after release is requester 0.
2. Single transfer: in_valid=4'b0100, in_data[2]=32'hCAFE_0002; bench acks 3 cycles after tx_req rises and drops ack 3 cycles after tx_req falls (PS=2).
   - in_ready=4'b0100 for 1 cycle; tx_req high the next cycle with tx_data=32'hCAFE_0002.
   - tx_req falls PS cycles after ack rises; busy falls PS+1 cycles after ack falls.
3. Round-robin: all four requesters held valid with distinct data and an auto-responder -> accept order 0,1,2,3,0,1. grant_id tracks each accept; no requester is skipped.
4. Fairness with a gap: in_valid=4'b1001 continuously -> order 0,3,0,3. Raising requester 2 while grant_id=0 results in the next grant going to 2 before 3.
5. Reset mid-handshake: assert nreset=0 while in REQ with tx_req=1 -> tx_req=0 on that edge and state is IDLE. After release with tx_ack=0, the next accept proceeds normally.
6. Stuck ack: hold tx_ack=1 before acceptance -> REQ lasts 1 cycle and the FSM waits in RELEASE (busy=1, in_ready=0). Releasing tx_ack returns the FSM to IDLE PS+1 cycles later.
